// File: rtl/riscv_amo_pkg.sv
// Shared types and helpers for the RV64A atomic memory operation unit.
package riscv_amo_pkg;

   typedef enum logic [4:0] {
      AMO_ADD  = 5'b00000,
      AMO_SWAP = 5'b00001,
      AMO_XOR  = 5'b00100,
      AMO_OR   = 5'b01000,
      AMO_AND  = 5'b01100,
      AMO_MIN  = 5'b10000,
      AMO_MAX  = 5'b10100,
      AMO_MINU = 5'b11000,
      AMO_MAXU = 5'b11100
   } amo_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } amo_state_e;

   // Byte enables for the addressed word or the whole doubleword.
   function automatic logic [7:0] amo_bmask(input logic word, input logic hi);
      logic [7:0] m;
      if (!word) begin
         m = 8'hFF;
      end else if (hi) begin
         m = 8'hF0;
      end else begin
         m = 8'h0F;
      end
      return m;
   endfunction

endpackage

// File: rtl/riscv_amo_alu.sv
// Combinational AMO operation: new memory value from old value and rs2.
module riscv_amo_alu
   import riscv_amo_pkg::*;
(
   input  logic [4:0]  funct,
   input  logic        word,
   input  logic [63:0] old_value,
   input  logic [63:0] operand,
   output logic [63:0] result
);

   logic [31:0] a_w_s;
   logic [31:0] b_w_s;
   logic [31:0] r_w_s;
   logic [63:0] r_d_s;
   logic        lt_w_s;
   logic        ltu_w_s;
   logic        lt_d_s;
   logic        ltu_d_s;

   // Signed and unsigned orderings for both widths.
   always_comb begin
      a_w_s   = old_value[31:0];
      b_w_s   = operand[31:0];
      lt_w_s  = $signed(a_w_s) < $signed(b_w_s);
      ltu_w_s = a_w_s < b_w_s;
      lt_d_s  = $signed(old_value) < $signed(operand);
      ltu_d_s = old_value < operand;
   end

   // Word-width operation; unknown codes leave memory unchanged.
   always_comb begin
      case (funct)
         AMO_ADD:  r_w_s = a_w_s + b_w_s;
         AMO_SWAP: r_w_s = b_w_s;
         AMO_XOR:  r_w_s = a_w_s ^ b_w_s;
         AMO_AND:  r_w_s = a_w_s & b_w_s;
         AMO_OR:   r_w_s = a_w_s | b_w_s;
         AMO_MIN:  r_w_s = lt_w_s  ? a_w_s : b_w_s;
         AMO_MAX:  r_w_s = lt_w_s  ? b_w_s : a_w_s;
         AMO_MINU: r_w_s = ltu_w_s ? a_w_s : b_w_s;
         AMO_MAXU: r_w_s = ltu_w_s ? b_w_s : a_w_s;
         default:  r_w_s = a_w_s;
      endcase
   end

   // Doubleword-width operation.
   always_comb begin
      case (funct)
         AMO_ADD:  r_d_s = old_value + operand;
         AMO_SWAP: r_d_s = operand;
         AMO_XOR:  r_d_s = old_value ^ operand;
         AMO_AND:  r_d_s = old_value & operand;
         AMO_OR:   r_d_s = old_value | operand;
         AMO_MIN:  r_d_s = lt_d_s  ? old_value : operand;
         AMO_MAX:  r_d_s = lt_d_s  ? operand : old_value;
         AMO_MINU: r_d_s = ltu_d_s ? old_value : operand;
         AMO_MAXU: r_d_s = ltu_d_s ? operand : old_value;
         default:  r_d_s = old_value;
      endcase
   end

   // A word result is replicated so either half of the bus carries it.
   always_comb begin
      if (word) begin
         result = {r_w_s, r_w_s};
      end else begin
         result = r_d_s;
      end
   end

endmodule

// File: rtl/riscv_amo_unit.sv
// RV64A AMO sequencer: one read then one write over a single-beat memory port.
module riscv_amo_unit
   import riscv_amo_pkg::*;
(
   input  logic        i_riscv_amo_clk,
   input  logic        i_riscv_amo_rst,
   input  logic        i_riscv_amo_start,
   input  logic [4:0]  i_riscv_amo_funct,
   input  logic        i_riscv_amo_word,
   input  logic [63:0] i_riscv_amo_addr,
   input  logic [63:0] i_riscv_amo_rs2,
   input  logic        i_riscv_amo_kill,
   output logic        o_riscv_amo_mem_req,
   output logic        o_riscv_amo_mem_we,
   output logic [63:0] o_riscv_amo_mem_addr,
   output logic [7:0]  o_riscv_amo_mem_bmask,
   output logic [63:0] o_riscv_amo_mem_wdata,
   input  logic        i_riscv_amo_mem_ready,
   input  logic [63:0] i_riscv_amo_mem_rdata,
   output logic        o_riscv_amo_stall,
   output logic        o_riscv_amo_done,
   output logic [63:0] o_riscv_amo_rd_value
);

   amo_state_e  state_r;
   logic [4:0]  funct_r;
   logic        word_r;
   logic        addr_hi_r;
   logic [63:0] rs2_r;
   logic        req_r;
   logic        we_r;
   logic        done_r;
   logic [7:0]  bmask_r;
   logic [63:0] mem_addr_r;
   logic [63:0] wdata_r;
   logic [63:0] rd_value_r;
   logic [31:0] word_s;
   logic [63:0] old_s;
   logic [63:0] alu_s;
   logic        stall_s;
   logic        unused_s;

   // Alignment is guaranteed, so the byte offset within a word carries no information.
   assign unused_s = ^i_riscv_amo_addr[1:0];

   // Select and sign-extend the old memory value from the returned doubleword.
   always_comb begin
      if (addr_hi_r) begin
         word_s = i_riscv_amo_mem_rdata[63:32];
      end else begin
         word_s = i_riscv_amo_mem_rdata[31:0];
      end
      if (word_r) begin
         old_s = {{32{word_s[31]}}, word_s};
      end else begin
         old_s = i_riscv_amo_mem_rdata;
      end
   end

   riscv_amo_alu u_alu (
      .funct     (funct_r),
      .word      (word_r),
      .old_value (old_s),
      .operand   (rs2_r),
      .result    (alu_s)
   );

   // Pipeline hold: asserted from the accepting cycle until the write completes.
   always_comb begin
      if (i_riscv_amo_rst) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE:  stall_s = i_riscv_amo_start & ~i_riscv_amo_kill;
            ST_READ:  stall_s = 1'b1;
            ST_WRITE: stall_s = 1'b1;
            default:  stall_s = 1'b0;
         endcase
      end
   end

   // Sequencer with registered memory-port and completion outputs.
   always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
      if (i_riscv_amo_rst) begin
         state_r    <= ST_IDLE;
         funct_r    <= 5'd0;
         word_r     <= 1'b0;
         addr_hi_r  <= 1'b0;
         rs2_r      <= 64'd0;
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         done_r     <= 1'b0;
         bmask_r    <= 8'd0;
         mem_addr_r <= 64'd0;
         wdata_r    <= 64'd0;
         rd_value_r <= 64'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (i_riscv_amo_start && !i_riscv_amo_kill) begin
                  funct_r    <= i_riscv_amo_funct;
                  word_r     <= i_riscv_amo_word;
                  addr_hi_r  <= i_riscv_amo_addr[2];
                  rs2_r      <= i_riscv_amo_rs2;
                  mem_addr_r <= {i_riscv_amo_addr[63:3], 3'b000};
                  bmask_r    <= amo_bmask(i_riscv_amo_word, i_riscv_amo_addr[2]);
                  req_r      <= 1'b1;
                  we_r       <= 1'b0;
                  wdata_r    <= 64'd0;
                  state_r    <= ST_READ;
               end
            end
            ST_READ: begin
               // Once the read has returned the write is committed regardless of kill.
               if (i_riscv_amo_mem_ready) begin
                  rd_value_r <= old_s;
                  wdata_r    <= alu_s;
                  we_r       <= 1'b1;
                  state_r    <= ST_WRITE;
               end else if (i_riscv_amo_kill) begin
                  req_r   <= 1'b0;
                  bmask_r <= 8'd0;
                  state_r <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (i_riscv_amo_mem_ready) begin
                  req_r   <= 1'b0;
                  we_r    <= 1'b0;
                  bmask_r <= 8'd0;
                  wdata_r <= 64'd0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               req_r   <= 1'b0;
               we_r    <= 1'b0;
               bmask_r <= 8'd0;
               wdata_r <= 64'd0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_riscv_amo_mem_req   = req_r;
   assign o_riscv_amo_mem_we    = we_r;
   assign o_riscv_amo_mem_addr  = mem_addr_r;
   assign o_riscv_amo_mem_bmask = bmask_r;
   assign o_riscv_amo_mem_wdata = wdata_r;
   assign o_riscv_amo_stall     = stall_s;
   assign o_riscv_amo_done      = done_r;
   assign o_riscv_amo_rd_value  = rd_value_r;

endmodule

// File: doc/riscv_amo_unit.md
RISCV_AMO_UNIT -- requirements
Module: riscv_amo_unit

Interface
REQ-001 SHALL have exactly one clock and one asynchronous active-high reset; no other clocks or resets.
REQ-002 Ports (name  direction  width  meaning):
- i_riscv_amo_clk  in  1  clock.
- i_riscv_amo_rst  in  1  asynchronous active-high reset.
- i_riscv_amo_start  in  1  AMO valid in MEM stage.
- i_riscv_amo_funct  in  5  funct5 opcode.
- i_riscv_amo_word  in  1  1=.W, 0=.D.
- i_riscv_amo_addr  in  64  rs1 address, naturally aligned.
- i_riscv_amo_rs2  in  64  operand.
- i_riscv_amo_kill  in  1  trap/flush.
- o_riscv_amo_mem_req  out  1  memory request.
- o_riscv_amo_mem_we  out  1  1=write.
- o_riscv_amo_mem_addr  out  64  {addr[63:3],3'b000}.
- o_riscv_amo_mem_bmask  out  8  byte enables.
- o_riscv_amo_mem_wdata  out  64  write data.
- i_riscv_amo_mem_ready  in  1  request accepted and completed this cycle.
- i_riscv_amo_mem_rdata  in  64  aligned doubleword, valid with ready on a read.
- o_riscv_amo_stall  out  1  hold pipeline.
- o_riscv_amo_done  out  1  one-cycle completion pulse.
- o_riscv_amo_rd_value  out  64  old memory value for rd.

Function
REQ-003 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-004 IDLE: start=1 and kill=0 SHALL latch funct, word, addr and rs2, then go to READ; start with kill=1 SHALL be ignored.
REQ-005 READ: req=1, we=0; on ready the unit SHALL capture the old value and go to WRITE.
REQ-006 Old value SHALL be rdata for .D; for .W it SHALL be rdata[63:32] when addr[2]=1, else rdata[31:0], sign-extended to 64 bits.
REQ-007 WRITE: req=1, we=1, wdata=ALU result; on ready the unit SHALL go to DONE.
REQ-008 DONE: done=1 for exactly one cycle, then IDLE.
REQ-009 rd_value SHALL hold the sign-extended old value from READ-capture until the next capture.
REQ-010 ALU ops by funct5: 00000 ADD, 00001 SWAP, 00100 XOR, 01100 AND, 01000 OR, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU.
REQ-011 Any other funct5 code SHALL write the old value back unchanged.
REQ-012 .W ops SHALL compute on the low 32 bits only; MIN/MAX SHALL compare signed 32-bit, MINU/MAXU unsigned 32-bit; ADD SHALL wrap modulo 2^32 (.W) or 2^64 (.D).
REQ-013 .W write data SHALL be placed in both 32-bit halves of wdata; bmask SHALL be 8'hF0 when addr[2]=1, else 8'h0F; .D bmask SHALL be 8'hFF; READ bmask SHALL equal the WRITE bmask.
REQ-014 stall SHALL be combinationally 1 when (IDLE and start and !kill), and in READ and WRITE; it SHALL be 0 in IDLE otherwise and in DONE.
REQ-015 Latency with ready tied high SHALL be: start at cycle 0, READ at cycle 1, WRITE at cycle 2, done at cycle 3.
REQ-016 Ready may be held low indefinitely; state and all outputs SHALL remain stable while waiting.
REQ-017 kill in READ before ready SHALL abort to IDLE with no write, no done and rd_value unchanged.
REQ-018 kill in the same cycle as READ ready, or in WRITE or DONE, SHALL be ignored; the write SHALL always complete for atomicity.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 When req=0, we, bmask and wdata SHALL be 0.

Reset
REQ-021 Reset SHALL force state=IDLE and set req, we, bmask, wdata, addr, stall, done and rd_value to 0, asynchronously.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no further memory request.

Structure
REQ-023 Package riscv_amo_pkg SHALL hold the funct5 enum and the FSM state enum.
REQ-024 Sub-module riscv_amo_alu SHALL hold the purely combinational op/width logic; the FSM and registers SHALL stay in riscv_amo_unit.

Verification
REQ-025 AMOADD.D: addr=0x1000, rs2=5, rdata=0x10, ready high -> read at cycle 1, write wdata=0x15 bmask=0xFF at cycle 2, done at cycle 3, rd_value=0x10.
REQ-026 AMOMIN.W: addr=0x1004, rs2=0x00000001, rdata=0xFFFFFFFF_00000000 -> rd_value=0xFFFFFFFF_FFFFFFFF, wdata=0xFFFFFFFF_FFFFFFFF, bmask=0xF0.
REQ-027 AMOMAXU.W: addr=0x2000, rs2=0x80000000, rdata low=0x7FFFFFFF -> wdata=0x80000000_80000000, bmask=0x0F, rd_value=0x7FFFFFFF.
REQ-028 Ready low for 4 cycles in READ and 3 cycles in WRITE -> outputs stable, stall high throughout, single done pulse.
REQ-029 kill in READ with ready low -> IDLE next cycle, no we=1 ever seen; kill in WRITE -> write still completes and done pulses.
REQ-030 Reset asserted in WRITE -> all outputs 0 immediately; a new start after reset release runs normally.
